// File: rtl/stream_mux_rr_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg: shared constants for the stream_mux_rr slice.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   sel_width()          : width of a channel index for n channels.
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if: bundle of the mux control, producer and consumer signals.
//   mode, SEL                      : selection control
//   in_data/in_valid/in_last       : producer side, NUM_CH lanes
//   in_ready                       : per-lane back-pressure (combinational)
//   out_data/out_ch/out_valid      : registered consumer side
//   out_ready                      : consumer back-pressure
// Modports: slave = the mux itself, master = the environment driving it.
// ---------------------------------------------------------------------------
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 2
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic                      mode;
  logic [SEL_W-1:0]          SEL;
  logic [NUM_CH*WIDTH-1:0]   in_data;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic [NUM_CH-1:0]         in_last;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  mode, SEL, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output mode, SEL, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface : stream_mux_rr_if

// File: rtl/stream_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: round-robin request arbiter that owns the rotation pointer.
//   clk, rst     : clock, async active-high reset (pointer returns to 0)
//   req          : per-channel request vector
//   advance      : a transfer completed on adv_idx; move pointer past it
//   adv_idx      : channel that completed the transfer
//   grant        : one-hot grant
//   grant_idx    : index of the granted channel
//   grant_valid  : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  adv_idx,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;
  logic [SEL_W:0]   cand;

  // First requester at or above the pointer, wrapping at NUM_CH-1.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_CH)) begin
        cand = cand - (SEL_W+1)'(NUM_CH);
      end
      if (!grant_valid && req[cand[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SEL_W-1:0];
      end
    end
    grant = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // Pointer moves to the channel after the one just served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      if ({1'b0, adv_idx} == (SEL_W+1)'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = adv_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr: N-channel stream multiplexer with a registered output stage.
// Selection is either fixed (SEL) or round-robin across valid channels.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : stream_mux_rr_if.slave (mode, SEL, in_*, out_*)
// Optional build macro STREAM_MUX_LOCK_EN: in round-robin mode a channel that
// transfers a word with in_last=0 keeps the grant until it sends in_last=1.
// ---------------------------------------------------------------------------
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 2,
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);

  logic [NUM_CH-1:0] arb_grant;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_valid;

  logic [SEL_W-1:0]  grant_idx_c;
  logic [NUM_CH-1:0] grant_oh_c;
  logic              grant_valid_c;
  logic              sel_ok_c;
  logic [WIDTH-1:0]  sel_data_c;
  logic              load_c;
  logic              xfer_c;
  logic              advance_c;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;

`ifdef STREAM_MUX_LOCK_EN
  logic              lock_q,      lock_d;
  logic [SEL_W-1:0]  locked_ch_q, locked_ch_d;
`else
  logic              unused_last;
  assign unused_last = ^bus.in_last;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .advance     (advance_c),
    .adv_idx     (grant_idx_c),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Grant selection: fixed SEL, held lock, or the round-robin arbiter.
  always_comb begin
    grant_idx_c   = '0;
    grant_oh_c    = '0;
    grant_valid_c = 1'b0;
    sel_ok_c      = ({1'b0, bus.SEL} < (SEL_W+1)'(NUM_CH));
    if (bus.mode == MODE_FIXED) begin
      if (sel_ok_c && bus.in_valid[bus.SEL]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = bus.SEL;
        grant_oh_c    = NUM_CH'(1) << bus.SEL;
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    else if (lock_q) begin
      if (bus.in_valid[locked_ch_q]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = locked_ch_q;
        grant_oh_c    = NUM_CH'(1) << locked_ch_q;
      end
    end
`endif
    else begin
      grant_valid_c = arb_valid;
      grant_idx_c   = arb_idx;
      grant_oh_c    = arb_grant;
    end
  end

  // Data lane of the granted channel.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_idx_c == SEL_W'(k)) begin
        sel_data_c = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: the output register can take a word when empty or draining.
  always_comb begin
    load_c       = !out_valid_q || bus.out_ready;
    xfer_c       = grant_valid_c && load_c && !rst;
    bus.in_ready = xfer_c ? grant_oh_c : '0;
`ifdef STREAM_MUX_LOCK_EN
    // Pointer only rotates once a packet ends.
    advance_c    = xfer_c && (bus.mode == MODE_RR) && bus.in_last[grant_idx_c];
`else
    advance_c    = xfer_c && (bus.mode == MODE_RR);
`endif
  end

  // Output register next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_c;
      out_ch_d    = grant_idx_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // Lock tracking applies to round-robin transfers only.
  always_comb begin
    lock_d      = lock_q;
    locked_ch_d = locked_ch_q;
    if (xfer_c && (bus.mode == MODE_RR)) begin
      if (!bus.in_last[grant_idx_c]) begin
        lock_d      = 1'b1;
        locked_ch_d = grant_idx_c;
      end else begin
        lock_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q      <= 1'b0;
      locked_ch_q <= '0;
    end else begin
      lock_q      <= lock_d;
      locked_ch_q <= locked_ch_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr: self-checking bench for stream_mux_rr (NUM_CH=4, WIDTH=2).
// A negedge monitor keeps a reference model of grant/pointer/lock state,
// pushes expected words on accepted inputs and pops them on output handshakes.
// Scenario tasks add directed checks on top.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 2;

  logic clk;
  logic rst;

  stream_mux_rr_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  stream_mux_rr #(.WIDTH(W), .NUM_CH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] sb[$];

  // Reference model state
  logic       m_valid;
  int         m_ptr;
  logic       m_lock;
  int         m_lch;
  logic       m_load;
  logic       m_gv;
  int         m_g;
  int         m_c;
  logic [3:0] m_exp_rdy;
  logic [3:0] m_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Scoreboard monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_lock  = 1'b0;
      m_lch   = 0;
      sb.delete();
    end else begin
      checks++;
      if (bus.out_valid !== m_valid) begin
        failures++;
        $display("FAIL mon_out_valid: got %b expected %b at %0t", bus.out_valid, m_valid, $time);
      end

      m_load = !m_valid || bus.out_ready;
      m_gv   = 1'b0;
      m_g    = 0;
      if (bus.mode == 1'b0) begin
        if (bus.in_valid[bus.SEL]) begin
          m_gv = 1'b1;
          m_g  = int'(bus.SEL);
        end
      end else if (m_lock) begin
        if (bus.in_valid[m_lch]) begin
          m_gv = 1'b1;
          m_g  = m_lch;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          m_c = (m_ptr + i) % 4;
          if (!m_gv && bus.in_valid[m_c]) begin
            m_gv = 1'b1;
            m_g  = m_c;
          end
        end
      end
      m_exp_rdy = (m_load && m_gv) ? (4'b0001 << m_g) : 4'b0000;
      checks++;
      if (bus.in_ready !== m_exp_rdy) begin
        failures++;
        $display("FAIL mon_in_ready: got %b expected %b at %0t", bus.in_ready, m_exp_rdy, $time);
      end

      if (m_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL mon_sb_empty: got word %b/%0d expected none at %0t", bus.out_data, bus.out_ch, $time);
        end else begin
          m_exp = sb.pop_front();
          if ({bus.out_data, bus.out_ch} !== m_exp) begin
            failures++;
            $display("FAIL mon_word: got data=%b ch=%0d expected data=%b ch=%0d at %0t",
                     bus.out_data, bus.out_ch, m_exp[3:2], m_exp[1:0], $time);
          end
        end
      end

      if (m_load && m_gv) begin
        sb.push_back({bus.in_data[m_g*2 +: 2], 2'(m_g)});
        m_valid = 1'b1;
        if (bus.mode == 1'b1) begin
`ifdef STREAM_MUX_LOCK_EN
          if (!bus.in_last[m_g]) begin
            m_lock = 1'b1;
            m_lch  = m_g;
          end else begin
            m_lock = 1'b0;
            m_ptr  = (m_g + 1) % 4;
          end
`else
          m_ptr = (m_g + 1) % 4;
`endif
        end
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic idle();
    bus.in_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.mode      = 1'b1;
    bus.SEL       = 2'd0;
    bus.in_data   = 8'b11_10_01_00;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 2'b00 || bus.out_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_out_word: got data=%b ch=%0d expected 00/0", bus.out_data, bus.out_ch);
    end
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
    end
    bus.in_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_fixed();
    logic [1:0] exp_d[4];
    exp_d = '{2'b00, 2'b01, 2'b01, 2'b11};
    bus.mode      = 1'b0;
    bus.SEL       = 2'd0;
    bus.in_data   = 8'b11_01_01_00;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_data !== exp_d[k] || bus.out_ch !== 2'(k) || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL fixed_word%0d: got data=%b ch=%0d v=%b expected data=%b ch=%0d v=1",
                 k, bus.out_data, bus.out_ch, bus.out_valid, exp_d[k], k);
      end
      bus.SEL = 2'(k + 1);
    end
    idle();
  endtask

  task automatic test_rr_all();
    bus.mode     = 1'b1;
    bus.in_data  = 8'b10_01_11_00;
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== (4'b0001 << (k % 4))) begin
        failures++;
        $display("FAIL rr_all_ready%0d: got %b expected %b", k, bus.in_ready, 4'b0001 << (k % 4));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_ch !== 2'(k % 4) || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_all_ch%0d: got ch=%0d v=%b expected ch=%0d v=1", k, bus.out_ch, bus.out_valid, k % 4);
      end
    end
    idle();
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch[3];
    exp_ch = '{2'd3, 2'd1, 2'd3};
    bus.mode     = 1'b1;
    bus.in_data  = 8'b01_10_11_00;
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ((bus.in_ready & 4'b0101) !== 4'b0000) begin
        failures++;
        $display("FAIL rr_sparse_idle_ready%0d: got %b expected ch0/ch2 low", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_ch !== exp_ch[k]) begin
        failures++;
        $display("FAIL rr_sparse_ch%0d: got %0d expected %0d", k, bus.out_ch, exp_ch[k]);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back_hold();
    bus.mode      = 1'b1;
    bus.in_data   = 8'b00_01_11_10;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_data !== 2'b10 || bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL hold%0d: got data=%b ch=%0d v=%b rdy=%b expected 10/0/1/0000",
                 k, bus.out_data, bus.out_ch, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_data !== 2'b11 || bus.out_ch !== 2'd1) begin
      failures++;
      $display("FAIL hold_resume: got data=%b ch=%0d expected 11/1", bus.out_data, bus.out_ch);
    end
    idle();
  endtask

  task automatic test_lock();
    logic [1:0] exp_ch[4];
    int         sent;
    logic       acc;
`ifdef STREAM_MUX_LOCK_EN
    exp_ch = '{2'd2, 2'd2, 2'd2, 2'd0};
`else
    exp_ch = '{2'd2, 2'd0, 2'd2, 2'd0};
`endif
    sent         = 0;
    bus.mode     = 1'b1;
    bus.in_data  = 8'b00_01_00_11;
    bus.in_last  = 4'b1011;
    bus.in_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = bus.in_ready[2];
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_ch !== exp_ch[k]) begin
        failures++;
        $display("FAIL lock_ch%0d: got %0d expected %0d", k, bus.out_ch, exp_ch[k]);
      end
      bus.in_valid[0] = 1'b1;
      if (acc) sent++;
      if (sent >= 3) begin
        bus.in_valid[2] = 1'b0;
      end else begin
        bus.in_data[5:4] = 2'(sent + 1);
        bus.in_last[2]   = (sent == 2);
      end
    end
    bus.in_last = 4'b1111;
    idle();
  endtask

  task automatic test_reset_mid();
    bus.mode      = 1'b1;
    bus.in_data   = 8'b01_11_10_01;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_async: got v=%b rdy=%b expected 0/0000", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1 || bus.out_data !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_first: got ch=%0d v=%b data=%b expected 0/1/01",
               bus.out_ch, bus.out_valid, bus.out_data);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_back_to_back_hold();
    test_lock();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stream_mux_rr
